// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// No logic; compile-time definitions only.
// No flow control; consumed by div_step and div_seq_ctrl.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ITER  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } div_state_e;

    // Two's-complement magnitude when neg is set, otherwise passthrough.
    function automatic logic [DIV_WIDTH-1:0] cond_neg(input logic neg,
                                                      input logic [DIV_WIDTH-1:0] v);
        cond_neg = neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One non-restoring division iteration on {A,Q} against the divisor magnitude.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] a_sh;
    logic [WIDTH:0] d_ext;

    // Shift {A,Q} left, then subtract when A was non-negative, add when negative.
    always_comb begin
        a_sh  = {a_i[WIDTH-1:0], q_i[WIDTH-1]};
        d_ext = {1'b0, d_i};
        a_o   = a_i[WIDTH] ? (a_sh + d_ext) : (a_sh - d_ext);
        q_o   = {q_i[WIDTH-2:0], ~a_o[WIDTH]};
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential 32-bit signed/unsigned divider, one non-restoring step per cycle.
// Latency: done 35 cycles after the start edge (2 cycles on divide-by-zero).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_e             state_q,  state_d;
    logic [WIDTH-1:0]       dvd_q,    dvd_d;     // captured dividend (raw)
    logic [WIDTH-1:0]       dvs_q,    dvs_d;     // captured divisor (raw)
    logic                   sgn_q,    sgn_d;
    logic [WIDTH-1:0]       dmag_q,   dmag_d;    // divisor magnitude
    logic [WIDTH:0]         a_q,      a_d;       // signed partial remainder
    logic [WIDTH-1:0]       q_q,      q_d;       // quotient shift register
    logic                   qneg_q,   qneg_d;
    logic                   rneg_q,   rneg_d;
    logic [DIV_CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]       quot_q,   quot_d;
    logic [WIDTH-1:0]       rem_q,    rem_d;
    logic                   dbz_q,    dbz_d;

    logic [WIDTH:0]         step_a;
    logic [WIDTH-1:0]       step_q;
    logic                   dvd_neg;
    logic                   dvs_neg;
    logic [WIDTH-1:0]       rem_mag;

    // Single shared iteration datapath, fed from the registered {A,Q}.
    div_step #(.WIDTH(WIDTH)) u_step (
        .a_i (a_q),
        .q_i (q_q),
        .d_i (dmag_q),
        .a_o (step_a),
        .q_o (step_q)
    );

    // Next-state and datapath decode from registered state; hold by default.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        sgn_d   = sgn_q;
        dmag_d  = dmag_q;
        a_d     = a_q;
        q_d     = q_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        dvd_neg = sgn_q & dvd_q[WIDTH-1];
        dvs_neg = sgn_q & dvs_q[WIDTH-1];
        // Final remainder fits in WIDTH bits, so the restore add can wrap safely.
        rem_mag = a_q[WIDTH-1:0] + (a_q[WIDTH] ? dmag_q : '0);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    sgn_d   = div_signed;
                    dbz_d   = 1'b0;
                end
            end
            S_INIT: begin
                if (dvs_q == '0) begin
                    // Skip the iterations entirely; result is all-ones / dividend.
                    state_d = S_DONE;
                    quot_d  = '1;
                    rem_d   = dvd_q;
                    dbz_d   = 1'b1;
                end else begin
                    state_d = S_ITER;
                    q_d     = cond_neg(dvd_neg, dvd_q);
                    dmag_d  = cond_neg(dvs_neg, dvs_q);
                    a_d     = '0;
                    cnt_d   = '0;
                    qneg_d  = dvd_neg ^ dvs_neg;
                    rneg_d  = dvd_neg;
                end
            end
            S_ITER: begin
                a_d   = step_a;
                q_d   = step_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DIV_CNT_W'(DIV_ITERS - 1)) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                // -0x80000000 wraps to itself, which covers MIN / -1.
                state_d = S_DONE;
                quot_d  = cond_neg(qneg_q, q_q);
                rem_d   = cond_neg(rneg_q, rem_mag);
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All state and datapath registers; clear wins over any request.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            sgn_q   <= 1'b0;
            dmag_q  <= '0;
            a_q     <= '0;
            q_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            sgn_q   <= sgn_d;
            dmag_q  <= dmag_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Status and results straight from registered state.
    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        div_by_zero = dbz_q;
        quotient    = quot_q;
        remainder   = rem_q;
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed and random checks of div_seq_ctrl against a behavioural division model.
// Latency: checks done arrives 35 cycles (2 on divide-by-zero) after the start edge.
// Backpressure: exercises starts while busy and in the DONE cycle.
module tb_div_seq_ctrl;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic [7:0]  lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    exp_t last_exp;

    div_seq_ctrl #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .div_signed  (div_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division, remainder follows the dividend sign.
    function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.dz  = 1'b0;
        e.lat = 8'd35;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 8'd2;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000; e.r = 32'd0;
            end else begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Entered and left at a negedge. disturb adds busy-time starts, operand
    // changes after E0, and a start in the DONE cycle.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb);
        int   n;
        bit   got;
        exp_t e;
        start = 1'b1; div_signed = sgn; dividend = a; divisor = b;
        exp_q.push_back(model(sgn, a, b));
        @(posedge clock);
        n = 0; got = 0;
        while (n < 60 && !got) begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                start = 1'b0;
                chk("busy_after_start", {31'd0, busy}, 32'd1);
                chk("dbz_clear_on_start", {31'd0, div_by_zero}, 32'd0);
            end
            if (disturb) begin
                if (n == 3) begin
                    start = 1'b1; dividend = ~a; divisor = b + 32'd3; div_signed = ~sgn;
                end
                if (n == 5) start = 1'b0;
                if (n == 7) start = 1'b1;
                if (n == 8) start = 1'b0;
            end
            if (done) got = 1;
        end
        e = exp_q.pop_front();
        last_exp = e;
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("latency", n, {24'd0, e.lat});
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        if (disturb) begin
            start = 1'b1; dividend = 32'd77; divisor = 32'd1;
        end
        @(negedge clock);
        start = 1'b0;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_after_done", {31'd0, busy}, 32'd0);
        chk("quotient_held", quotient, e.q);
    endtask

    initial begin
        exp_t e;
        clear = 1'b1; start = 1'b0; div_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);

        // clear overrides start on the same edge
        start = 1'b1; dividend = 32'd10; divisor = 32'd3;
        @(negedge clock);
        chk("clear_over_start", {31'd0, busy}, 32'd0);
        clear = 1'b0; start = 1'b0;
        @(negedge clock);
        chk("idle_no_start", {31'd0, busy}, 32'd0);

        do_div(1'b1, 32'd100, 32'd7, 1'b1);
        chk("spec_100_7_q", quotient, 32'd14);
        chk("spec_100_7_r", remainder, 32'd2);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("spec_m7_2_q", quotient, 32'hFFFF_FFFD);
        chk("spec_m7_2_r", remainder, 32'hFFFF_FFFF);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
        chk("spec_7_m2_q", quotient, 32'hFFFF_FFFD);
        chk("spec_7_m2_r", remainder, 32'd1);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd16, 1'b0);
        chk("spec_u_q", quotient, 32'h0FFF_FFFF);
        chk("spec_u_r", remainder, 32'd15);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("spec_min_q", quotient, 32'h8000_0000);
        chk("spec_min_r", remainder, 32'd0);
        do_div(1'b0, 32'd5, 32'd0, 1'b1);
        chk("spec_dbz_q", quotient, 32'hFFFF_FFFF);
        chk("spec_dbz_r", remainder, 32'd5);
        do_div(1'b0, 32'd9, 32'd4, 1'b0);

        // abort mid-iteration with clear
        start = 1'b1; div_signed = 1'b0; dividend = 32'd12; divisor = 32'd5;
        @(posedge clock);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            if (n == 1) start = 1'b0;
            chk("no_done_before_abort", {31'd0, done}, 32'd0);
        end
        clear = 1'b1;
        @(negedge clock);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        clear = 1'b0;
        do_div(1'b0, 32'd9, 32'd3, 1'b0);
        chk("after_abort_q", quotient, 32'd3);
        chk("after_abort_r", remainder, 32'd0);

        // random mix, back-to-back
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : $urandom_range(1, 300);
            if (i % 3 == 0) rb = -rb;
            do_div(1'(i % 2), ra, rb, 1'(i % 4 == 1));
        end

        // results hold while idle with inputs wiggling
        e = last_exp;
        dividend = 32'h1234_5678; divisor = 32'h0; div_signed = 1'b1;
        repeat (4) @(negedge clock);
        chk("hold_quotient", quotient, e.q);
        chk("hold_remainder", remainder, e.r);
        chk("hold_idle", {31'd0, busy}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is required to be supported.
REQ-002 Port: clock  in  1  rising-edge clock; single clock domain.
REQ-003 Port: clear  in  1  reset, synchronous, active-high.
REQ-004 Port: start  in  1  request a division; sampled only in IDLE.
REQ-005 Port: div_signed  in  1  1=two's-complement operands, 0=unsigned; captured with start.
REQ-006 Port: dividend  in  WIDTH  numerator; captured on the start edge.
REQ-007 Port: divisor  in  WIDTH  denominator; captured on the start edge.
REQ-008 Port: busy  out  1  high in every state except IDLE.
REQ-009 Port: done  out  1  one-cycle pulse; results valid while high and held after.
REQ-010 Port: div_by_zero  out  1  set with done when captured divisor==0.
REQ-011 Port: quotient  out  WIDTH  LO result.
REQ-012 Port: remainder  out  WIDTH  HI result.

Function
REQ-013 States SHALL be IDLE, INIT, ITER, FIXUP, DONE.
REQ-014 Transitions: IDLE->INIT on start; INIT->ITER, or INIT->DONE if divisor==0; ITER->FIXUP after 32 iterations; FIXUP->DONE; DONE->IDLE unconditionally.
REQ-015 Edge E0 samples start; operands and div_signed SHALL be registered at E0, and later input changes SHALL be ignored.
REQ-016 INIT (E1): register magnitudes of the operands (absolute value if signed), record the result signs, load the partial remainder A=0, and load iteration counter=0.
REQ-017 ITER SHALL perform exactly one non-restoring step per clock on E2..E33:
  - shift {A,Q} left by one;
  - subtract the divisor magnitude if A>=0, otherwise add it;
  - set the new Q bit to ~A[msb].
  - A SHALL be WIDTH+1 bits wide.
REQ-018 FIXUP (E34): if A<0, add the divisor magnitude back. Then apply signs: quotient negated iff the operand signs differ; remainder takes the sign of the dividend. Write quotient/remainder.
REQ-019 done SHALL be high exactly in the cycle after E34, which is 35 cycles after the start edge, for exactly one cycle.
REQ-020 Divide-by-zero: INIT->DONE at E1, giving quotient=0xFFFFFFFF, remainder=dividend, div_by_zero=1, and done high in the cycle after E1.
REQ-021 Signed quotient SHALL truncate toward zero. The case 0x80000000 / -1 SHALL give quotient=0x80000000, remainder=0, with no flag.
REQ-022 start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-023 quotient, remainder and div_by_zero SHALL hold their last values until the next FIXUP or divide-by-zero DONE; div_by_zero SHALL clear when the next start is accepted.
REQ-024 start high in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted. Back-to-back throughput is therefore one division per 36 cycles.

Reset
REQ-025 While clear=1 at an edge: state=IDLE, busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, counter=0.
REQ-026 clear SHALL override start on the same edge.
REQ-027 clear mid-operation SHALL abort without producing done; a start on the first edge after clear deasserts SHALL be accepted.

Structure
REQ-028 Shared package div_pkg SHALL hold:
  - the state enum;
  - DIV_WIDTH=32;
  - DIV_ITERS=32;
  - the counter width (6 bits).
REQ-029 A combinational sub-module div_step SHALL implement one non-restoring iteration, with inputs {A,Q} and divisor magnitude and output next {A,Q}. It SHALL be instantiated once and reused each ITER cycle.
REQ-030 All registers SHALL be updated in a single clocked process. The next-state and output decode SHALL be combinational from registered state.

Verification
REQ-031 Signed 100/7, start at E0 -> done in the cycle after E34; quotient=14, remainder=2, div_by_zero=0.
REQ-032 Signed -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
REQ-033 Unsigned 0xFFFFFFFF/16 -> quotient=0x0FFFFFFF, remainder=15. Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-034 5/0 -> done in the cycle after E1, div_by_zero=1, quotient=0xFFFFFFFF, remainder=5. The next valid start clears div_by_zero.
REQ-035 Edge handling:
  - start 12/5, then pulse clear during iteration 10 -> busy=0, outputs 0, no done;
  - a start on the next edge with 9/3 -> quotient=3, remainder=0;
  - start pulses while busy, and operand changes after E0, -> no effect on the result.
